// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART receive controller.
//   UART_RX_PARITY_EN (optional define) adds the PARITY state for 8E1 frames.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_rx_state_t;

endpackage

// File: rtl/shift_register.sv
// shift_register
//   Generic serial-in / parallel-out shift register with parallel load.
//   Shifting moves toward bit 0; serial_in enters the MSB.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous clear, active high
//   load_enable  load parallel_in (priority over shift)
//   shift_enable shift one position
//   serial_in    bit entering the MSB on shift
//   parallel_in  parallel load value
//   parallel_out current register contents
module shift_register #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  logic [NUM_BITS-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load_enable) begin
      r_q <= parallel_in;
    end else if (shift_enable) begin
      r_q <= {serial_in, r_q[NUM_BITS-1:1]};
    end
  end

  assign parallel_out = r_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   UART receive controller. Synchronizes uart_rx, detects the start bit,
//   samples each bit at mid-period and drives a shift_register that
//   deserializes LSB-first data. A good frame is committed into a one-entry
//   valid/ready holding register on the cycle after the stop sample.
//   Optional define UART_RX_PARITY_EN selects 8E1 framing (default 8N1).
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   uart_rx      raw serial line, idle high
//   rx_data      received byte (stable while rx_valid and not consumed)
//   rx_valid     rx_data holds an unconsumed byte
//   rx_ready     consumer accept
//   frame_error  1-cycle pulse: stop bit sampled low
//   overrun      1-cycle pulse: completed byte dropped, holding reg full
//   parity_error 1-cycle pulse: parity mismatch (0 without parity build)
//   busy         FSM not in IDLE
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | line idle, waiting for rx_s low
// START    | half-bit wait, confirm start bit (glitch filter)
// DATA     | sample and shift 8 data bits
// PARITY   | sample even-parity bit (parity build only)
// STOP     | sample stop bit
// BREAK    | stop bit was low; wait for line to return high
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_error,
  output logic                      overrun,
  output logic                      parity_error,
  output logic                      busy
);

  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

  uart_rx_state_t r_state, w_next_state;

  logic [SYNC_STAGES-1:0]    r_sync;
  logic [15:0]               r_baud;
  logic [2:0]                r_bit_idx;
  logic                      r_commit;
  logic [UART_DATA_BITS-1:0] r_rx_data;
  logic                      r_rx_valid;

  logic                      w_rx_s;
  logic                      w_cnt_zero;
  logic                      w_shift_en;
  logic                      w_stop_good;
  logic                      w_frame_err;
  logic                      w_par_err;
  logic                      w_discard;
  logic [UART_DATA_BITS-1:0] w_shift_q;

  // Synchronizer flops reset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
  end

  assign w_rx_s     = r_sync[SYNC_STAGES-1];
  assign w_cnt_zero = (r_baud == 16'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (!w_rx_s) w_next_state = ST_START;
      ST_START: if (w_cnt_zero) w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (w_cnt_zero && r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (w_cnt_zero) w_next_state = ST_STOP;
`endif
      ST_STOP:  if (w_cnt_zero) w_next_state = w_rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (w_rx_s) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_shift_en  = 1'b0;
    w_stop_good = 1'b0;
    w_frame_err = 1'b0;
    w_par_err   = 1'b0;
    case (r_state)
      ST_DATA: w_shift_en = w_cnt_zero;
`ifdef UART_RX_PARITY_EN
      // Data+parity must XOR to 0 for even parity.
      ST_PARITY: w_par_err = w_cnt_zero & ((^w_shift_q) ^ w_rx_s);
`endif
      ST_STOP: begin
        w_stop_good = w_cnt_zero & w_rx_s;
        w_frame_err = w_cnt_zero & ~w_rx_s;
      end
      default: ;
    endcase
  end

  assign busy         = (r_state != ST_IDLE);
  assign frame_error  = w_frame_err;
  assign parity_error = w_par_err;

  // Baud counter and bit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud    <= 16'd0;
      r_bit_idx <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (!w_rx_s) r_baud <= HALF_LOAD;
        ST_START:
          if (w_cnt_zero) begin
            r_baud    <= FULL_LOAD;
            r_bit_idx <= 3'd0;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        ST_DATA:
          if (w_cnt_zero) begin
            r_baud    <= FULL_LOAD;
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
`ifdef UART_RX_PARITY_EN
        ST_PARITY:
          if (w_cnt_zero) r_baud <= FULL_LOAD;
          else            r_baud <= r_baud - 16'd1;
`endif
        ST_STOP: if (!w_cnt_zero) r_baud <= r_baud - 16'd1;
        default: ;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  // Remember a parity failure until the stop sample decides the commit.
  logic r_par_bad;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_par_bad <= 1'b0;
    else if (r_state == ST_START) r_par_bad <= 1'b0;
    else if (w_par_err)       r_par_bad <= 1'b1;
  end
  assign w_discard = r_par_bad;
`else
  assign w_discard = 1'b0;
`endif

  // Commit request lands one cycle after the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_commit <= 1'b0;
    else        r_commit <= w_stop_good & ~w_discard;
  end

  // Holding register: a commit wins over a same-cycle consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (r_commit && (!r_rx_valid || rx_ready)) begin
      r_rx_data  <= w_shift_q;
      r_rx_valid <= 1'b1;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign overrun  = r_commit & r_rx_valid & ~rx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

  // Contents need no reset: only read after 8 fresh shifts.
  shift_register #(
    .NUM_BITS (UART_DATA_BITS)
  ) u_shift (
    .clk          (clk),
    .rst          (1'b0),
    .load_enable  (1'b0),
    .shift_enable (w_shift_en),
    .serial_in    (w_rx_s),
    .parallel_in  ({UART_DATA_BITS{1'b0}}),
    .parallel_out (w_shift_q)
  );

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller that sequences an 8-bit `shift_register` instance to deserialize 8N1 frames from the `uart_rx` pin.
- Synchronizes the line and detects the start bit.
- Samples each bit at mid-period and pulses `shift_enable` once per data bit.
- Checks the stop bit and presents the byte through a one-entry valid/ready holding register.
- Feeds the program loader that writes the RV32I instruction memory.

Parameters:
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- `SYNC_STAGES`, 2, flops in the `uart_rx` input synchronizer; minimum 2.

Ports:
- `clk`  input  1  system clock; all state on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `uart_rx`  input  1  raw serial line; idle high.
- `rx_data`  output  8  received byte held in the output register.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  input  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `frame_error`  output  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.
- `parity_error`  output  1  one-cycle pulse on parity mismatch; tied 0 when the optional feature is absent.
- `busy`  output  1  high whenever state != IDLE.

Behaviour:
- Reset values while `rst_n` = 0:
  - State IDLE; baud counter 0; bit index 0.
  - Synchronizer flops all 1.
  - `rx_data` = 8'h00; `rx_valid`, `frame_error`, `overrun`, `parity_error`, `busy` all 0.
- Reset assertion mid-frame aborts immediately; no partial byte is ever presented.
- Synchronizer: `uart_rx` passes through `SYNC_STAGES` flops giving `rx_s`. All decisions use `rx_s`.
- States: IDLE, START, DATA, [PARITY], STOP, BREAK.
- IDLE: `rx_s` = 0 -> START, baud counter loaded with `CLKS_PER_BIT/2 - 1` (floor).
- START: on counter = 0, sample `rx_s`.
  - 0 -> DATA; counter = `CLKS_PER_BIT-1`; bit index = 0.
  - 1 -> glitch; return to IDLE with no shift and no error.
- DATA: on counter = 0:
  - Pulse `shift_enable` for one cycle with `serial_in` = `rx_s`.
  - Reload the counter and increment the bit index.
  - After the 8th shift (index 7) -> PARITY if enabled, else STOP.
- Bit order: LSB first. The register shifts toward bit 0 and `serial_in` enters the MSB, so after 8 shifts `parallel_out` equals the transmitted byte.
- STOP: on counter = 0, sample `rx_s`.
  - 1 -> frame good; go to IDLE.
  - 0 -> pulse `frame_error`, discard the byte, go to BREAK.
- BREAK: stay until `rx_s` = 1, then IDLE. `busy` remains high.
- Good-frame commit happens on the cycle after the stop sample:
  - Holding register empty, or `rx_valid && rx_ready` that same cycle: `rx_data` <= `parallel_out`, `rx_valid` <= 1.
  - Holding register full and not being consumed: new byte dropped, `overrun` pulses, old byte retained.
- `rx_valid` clears on `rx_valid && rx_ready` unless a commit occurs in the same cycle.
- `rx_data` is stable while `rx_valid` = 1 and not consumed.
- Latency: `rx_valid` rises 1 cycle after the stop mid-bit sample. Total from the falling edge of `uart_rx` to `rx_valid` ≈ `SYNC_STAGES` + `CLKS_PER_BIT/2` + 9*`CLKS_PER_BIT` + 1 cycles.
- Back-to-back frames: IDLE is re-entered at stop mid-bit, so the next start edge is detected with no lost cycles.

Optional Feature:
`UART_RX_PARITY_EN`
- Defined:
  - Frame is 8E1. PARITY state samples the 9th bit at mid-period.
  - Even parity over data+parity must be 0; a mismatch pulses `parity_error` at the parity sample and the byte is discarded at commit.
  - Stop checking is unchanged. If both parity and stop fail, `parity_error` and `frame_error` both pulse.
- Undefined: 8N1 only, no PARITY state, `parity_error` constant 0.

Decomposition:
- Package `uart_pkg`:
  - State enum `uart_rx_state_t`.
  - `UART_DATA_BITS` = 8.
  - Default `CLKS_PER_BIT` constant.
- Sub-module: one existing `shift_register` instance with `NUM_BITS` = 8, `load_enable` = 0, `parallel_in` = 0 and `rst` tied 0. Its contents need no reset because they are only consumed after 8 fresh shifts.
- Baud counter and FSM are inline.

Test Plan (`CLKS_PER_BIT` = 16, `SYNC_STAGES` = 2):
- Send frame 8'hA5 with `rx_ready` = 1 -> exactly 8 `shift_enable` pulses at mid-bits; `rx_valid` pulses for 1 cycle with `rx_data` = 8'hA5; no error pulses.
- Low glitch of 4 cycles on idle line -> `busy` high then IDLE after the half-bit sample; no shift, no `rx_valid`, no error.
- Frame 8'h3C with stop bit driven 0 for 40 cycles -> `frame_error` pulse, `rx_valid` stays 0, `busy` high until line returns 1; next frame 8'h11 received correctly.
- `rx_ready` = 0; send 8'h01 then 8'h02 -> `rx_data` = 8'h01 retained, `overrun` pulses at second commit; `rx_ready` = 1 then consumes 8'h01 and `rx_valid` = 0.
- Assert `rst_n` low mid-DATA after 4 bits -> all outputs reset asynchronously; after release, frame 8'hFF decodes to 8'hFF.
- With `UART_RX_PARITY_EN`: 8'h07 with parity bit 0 -> `parity_error` pulse, no `rx_valid`; same byte with parity bit 1 -> `rx_data` = 8'h07.
